// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state/owner types and grant-vector bit positions for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ADDR, RESP, ERR} state_t;
  typedef enum logic {OWN_IF, OWN_D} owner_t;
  localparam int GNT_IF = 0;
  localparam int GNT_D = 1;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: data-over-fetch priority, yielding to fetch once the data streak saturates
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       if_req,
  input  logic       d_req,
  input  logic       sat,
  output logic [1:0] gnt
);
  assign gnt[GNT_D] = d_req && !(sat && if_req);
  assign gnt[GNT_IF] = if_req && !gnt[GNT_D];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, one access at a time,
// each access bounded by a timeout that returns an error response to the owner
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 16,
  parameter int MAX_CONSEC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(MAX_CONSEC + 1);
  state_t state, state_nx;
  owner_t owner;
  logic [TW-1:0] timer;
  logic [CW-1:0] consec;
  logic [1:0] pick;
  logic idle, sat, timeout, resp_v;
  // grants are masked while rst is high so every output reads 0 during reset
  assign idle = state == IDLE && !rst;
  assign sat = consec == CW'(MAX_CONSEC);
  assign timeout = (state == ADDR || state == RESP) && timer == TW'(TIMEOUT - 1);
  assign resp_v = state == RESP && mem_rvalid;
  mem_arb_pick u_pick (.if_req(if_req), .d_req(d_req), .sat(sat), .gnt(pick));
  assign if_gnt = idle && pick[GNT_IF];
  assign d_gnt = idle && pick[GNT_D];
  assign busy = state != IDLE;
  assign mem_req = state == ADDR;
  assign if_rvalid = owner == OWN_IF && (resp_v || state == ERR);
  assign d_rvalid = owner == OWN_D && (resp_v || state == ERR);
  assign if_err = owner == OWN_IF && state == ERR;
  assign d_err = owner == OWN_D && state == ERR;
  assign if_rdata = (owner == OWN_IF && state == RESP) ? mem_rdata : '0;
  assign d_rdata = (owner == OWN_D && state == RESP) ? mem_rdata : '0;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = (if_gnt || d_gnt) ? ADDR : IDLE;
      ADDR: state_nx = timeout ? ERR : mem_gnt ? RESP : ADDR;
      RESP: state_nx = mem_rvalid ? IDLE : timeout ? ERR : RESP;
      ERR:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      owner <= OWN_IF;
      timer <= '0;
      consec <= '0;
      mem_we <= 1'b0;
      mem_be <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nx;
      timer <= (state == IDLE) ? '0 : timer + 1'b1;
      if (state == IDLE)
        consec <= (!if_req || if_gnt) ? '0 : (d_gnt && !sat) ? consec + 1'b1 : consec;
      if (if_gnt || d_gnt) begin
        owner <= d_gnt ? OWN_D : OWN_IF;
        mem_addr <= d_gnt ? d_addr : if_addr;
        mem_we <= d_gnt && d_we;
        mem_be <= d_gnt ? d_be : '1;
        mem_wdata <= d_gnt ? d_wdata : '0;
      end
    end
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port of the multicycle RV32I core between the instruction-fetch requester (FETCH state) and the data requester (MEM_READ / MEM_WRITE states). Accepts one request at a time, drives the memory handshake, routes the response back to the owner, and bounds every access with a timeout. Sits between the multicycle controller/datapath and the memory model.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables = DATA_W/8)
- TIMEOUT, 16, max cycles from request launch to response; ≥2
- MAX_CONSEC, 4, max back-to-back data grants while fetch waits; ≥1

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch accepted (1-cycle pulse)
- if_rvalid  out  1  fetch response valid (1-cycle pulse)
- if_rdata  out  DATA_W  fetch read data
- if_err  out  1  fetch timed out, qualifies if_rvalid
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store
- d_be  in  DATA_W/8  byte enables
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt, d_rvalid, d_rdata, d_err  out  1/1/DATA_W/1  as fetch equivalents
- mem_req  out  1  memory request
- mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  latched request fields
- mem_gnt  in  1  memory accepted mem_req
- mem_rvalid  in  1  memory response (read data or write ack)
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

## Operation
- FSM: IDLE, ADDR, RESP, ERR.
- IDLE: if any req, pick winner, assert its gnt combinationally this cycle, latch addr/we/be/wdata and owner, → ADDR. Fetch requests force mem_we=0, mem_be=all ones.
- Priority: data over fetch, unless consec counter == MAX_CONSEC and if_req=1, then fetch wins.
- consec: +1 on data grant while if_req=1; cleared on fetch grant or when if_req=0 in IDLE; saturates at MAX_CONSEC.
- ADDR: mem_req=1 with latched fields; on mem_gnt → RESP.
- RESP: owner rvalid = mem_rvalid, owner rdata = mem_rdata (combinational pass-through); on mem_rvalid → IDLE. Non-owner rvalid=0.
- Timeout: timer cleared on entering ADDR, counts every cycle in ADDR/RESP; when timer == TIMEOUT-1 with no mem_rvalid → ERR. mem_req drops on timeout.
- ERR (1 cycle): owner rvalid=1, err=1, rdata=0; → IDLE.
- Writes also complete on mem_rvalid (ack); rdata don't-care.
- Width: timer $clog2(TIMEOUT+1) bits, consec $clog2(MAX_CONSEC+1) bits.

## Timing
- Reset values: state IDLE, all outputs 0, timer 0, consec 0, latched fields 0.
- Min access: grant cycle N, mem_req cycle N+1 (mem_gnt same cycle), rvalid earliest N+2, IDLE N+3; next grant N+3.
- Exactly one outstanding access; gnt never asserted outside IDLE.
- mem_rvalid and timeout in the same cycle: response wins, err=0.
- mem_rvalid outside RESP (incl. stale response after reset/timeout): ignored.
- if_req and d_req both high in IDLE: exactly one gnt.
- rst mid-access: immediate return to IDLE, outputs 0, no response delivered to owner.
- Requester fields sampled only in grant cycle; later changes have no effect.

## Structure
- Package mem_arb_pkg: state enum (IDLE, ADDR, RESP, ERR), owner enum (OWN_IF, OWN_D).
- Sub-module mem_arb_pick: combinational priority selection from if_req, d_req, consec-saturated flag → grant vector. Rest in mem_port_arbiter.

## Test plan
- Fetch only, if_addr=0x100, mem_gnt immediate, mem_rvalid next cycle with 0xDEADBEEF -> if_gnt at N, mem_req at N+1 with addr 0x100 we=0 be=0xF, if_rvalid+if_rdata=0xDEADBEEF at N+2, busy=0 at N+3.
- Store d_addr=0x200, d_be=0x3, d_wdata=0x1234 -> mem_we=1, mem_be=0x3, mem_wdata=0x1234; d_rvalid on ack, if_rvalid stays 0.
- if_req and d_req high together continuously, MAX_CONSEC=4 -> grant order D,D,D,D,IF,D,...; never two gnts same cycle.
- mem_gnt held low, TIMEOUT=16 -> mem_req high 16 cycles then low, ERR cycle: d_rvalid=1, d_err=1, d_rdata=0; late mem_rvalid ignored.
- mem_rvalid on exact timeout cycle -> normal response, err=0.
- rst pulsed while in RESP -> all outputs 0 asynchronously, state IDLE, subsequent mem_rvalid produces no rvalid; next request served normally.
